// File: rtl/multibyte_add_sequencer_pkg.sv
// Shared types and constants for the byte-serial add/subtract sequencer.
// Holds the FSM state enum and the byte-index and byte-width constants.
package multibyte_add_sequencer_pkg;

    localparam int BYTES_MAX = 8;
    localparam int BYTE_W    = 8;
    localparam int IDX_W     = $clog2(BYTES_MAX);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/multibyte_add_sequencer_if.sv
// Request/response bundle for the byte-serial add/subtract sequencer.
// Sequencer = slave, requester/consumer = master.
interface multibyte_add_sequencer_if
    import multibyte_add_sequencer_pkg::*;
#(
    parameter int BYTES = 4
);
    localparam int W = BYTE_W * BYTES;

    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         sub;
    logic         cin;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] result;
    logic         cout;
    logic         flag_z;
    logic         flag_n;
    logic         flag_v;

    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    // Once raised, valid and its payload hold until that transfer; ready may depend on the
    // opposite side's ready, never on valid.
    modport master (
        output req_valid, op_a, op_b, sub, cin, rsp_ready,
        input  req_ready, rsp_valid, result, cout, flag_z, flag_n, flag_v
    );

    modport slave (
        input  req_valid, op_a, op_b, sub, cin, rsp_ready,
        output req_ready, rsp_valid, result, cout, flag_z, flag_n, flag_v
    );

endinterface

// File: rtl/multibyte_add_sequencer_rca8.sv
// The team's existing 8-bit ripple-carry adder: o = a + b + ci, co = carry out.
// Built as an explicit per-bit carry chain.
module ripple_carry_adder_8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       ci,
    output logic [7:0] o,
    output logic       co
);

    always_comb begin
        logic c;
        c = ci;
        o = '0;
        for (int i = 0; i < 8; i++) begin
            o[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        co = c;
    end

endmodule

// File: rtl/multibyte_add_sequencer.sv
// Wide add/subtract done byte-serially through one 8-bit adder, carry chained in a register.
// Define MBADD_FLAGS_EN to compute Z/N/V flags; otherwise the flag ports are tied to 0.
module multibyte_add_sequencer
    import multibyte_add_sequencer_pkg::*;
#(
    parameter int BYTES = 4
)(
    input  logic                      clk,
    input  logic                      rst_n,
    multibyte_add_sequencer_if.slave  bus,
    output state_e                    o_dbg_state
);

    localparam int              W        = BYTE_W * BYTES;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

    state_e             r_state;
    state_e             w_state_next;
    logic [IDX_W-1:0]   r_idx;
    logic               r_carry;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_result;
    logic [W-1:0]       w_result_next;
    logic [W-1:0]       w_b_eff;
    logic               w_accept;
    logic               w_last;
    logic               w_req_ready;
    logic               w_rsp_valid;
    logic [BYTE_W-1:0]  w_sum;
    logic               w_co;

    // Operands shift right each RUN cycle so the adder always sees the low byte.
    ripple_carry_adder_8 u_adder (
        .a  (r_a[BYTE_W-1:0]),
        .b  (r_b[BYTE_W-1:0]),
        .ci (r_carry),
        .o  (w_sum),
        .co (w_co)
    );

    assign w_b_eff = bus.sub ? ~bus.op_b : bus.op_b;
    assign w_last  = (r_idx == LAST_IDX);

    always_comb begin
        w_state_next = r_state;
        w_req_ready  = 1'b0;
        w_rsp_valid  = 1'b0;
        case (r_state)
            ST_IDLE: w_req_ready = rst_n;
            ST_RUN:  if (w_last) w_state_next = ST_DONE;
            ST_DONE: begin
                w_rsp_valid = 1'b1;
                w_req_ready = rst_n & bus.rsp_ready;
                if (bus.rsp_ready) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
        w_accept = w_req_ready & bus.req_valid;
        if (w_accept) w_state_next = ST_RUN;
    end

    always_comb begin
        w_result_next = r_result;
        for (int b = 0; b < BYTES; b++) begin
            if (r_idx == IDX_W'(b)) w_result_next[b*BYTE_W +: BYTE_W] = w_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_a     <= bus.op_a;
                r_b     <= w_b_eff;
                r_carry <= bus.sub ? 1'b1 : bus.cin;
                r_idx   <= '0;
            end else if (r_state == ST_RUN) begin
                r_result <= w_result_next;
                r_carry  <= w_co;
                r_a      <= r_a >> BYTE_W;
                r_b      <= r_b >> BYTE_W;
                if (!w_last) r_idx <= r_idx + 1'b1;
            end
        end
    end

`ifdef MBADD_FLAGS_EN
    logic r_msb_a;
    logic r_msb_b;
    logic r_flag_z;
    logic r_flag_n;
    logic r_flag_v;

    // Operand MSBs are captured at accept because the operand registers shift away.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_msb_a  <= 1'b0;
            r_msb_b  <= 1'b0;
            r_flag_z <= 1'b0;
            r_flag_n <= 1'b0;
            r_flag_v <= 1'b0;
        end else if (w_accept) begin
            r_msb_a <= bus.op_a[W-1];
            r_msb_b <= w_b_eff[W-1];
        end else if (r_state == ST_RUN && w_last) begin
            r_flag_z <= (w_result_next == '0);
            r_flag_n <= w_result_next[W-1];
            r_flag_v <= (r_msb_a == r_msb_b) & (w_result_next[W-1] != r_msb_a);
        end
    end

    assign bus.flag_z = r_flag_z;
    assign bus.flag_n = r_flag_n;
    assign bus.flag_v = r_flag_v;
`else
    assign bus.flag_z = 1'b0;
    assign bus.flag_n = 1'b0;
    assign bus.flag_v = 1'b0;
`endif

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = w_rsp_valid;
    assign bus.result    = r_result;
    assign bus.cout      = r_carry;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_multibyte_add_sequencer.sv
// Directed bench for multibyte_add_sequencer (BYTES=4): vector table, backpressure,
// back-to-back accept from DONE, and reset abandoning an operation mid-RUN.
module tb_multibyte_add_sequencer;
    import multibyte_add_sequencer_pkg::*;

    localparam int BYTES = 4;
    localparam int W     = 8 * BYTES;
`ifdef MBADD_FLAGS_EN
    localparam bit FLAGS_ON = 1'b1;
`else
    localparam bit FLAGS_ON = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic         cin;
        logic [W-1:0] res;
        logic         cout;
        logic         z;
        logic         n;
        logic         v;
    } vec_t;

    // clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multibyte_add_sequencer_if #(.BYTES(BYTES)) bus ();
    state_e dbg_state;

    multibyte_add_sequencer #(.BYTES(BYTES)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    int n_pass  = 0;
    int n_total = 0;
    logic [W-1:0] exp_q[$];
    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // driver: present a request at a negedge and hold it until it is taken
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic c);
        int t;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.op_a = a;
        bus.op_b = b;
        bus.sub  = s;
        bus.cin  = c;
        #1;
        t = 0;
        while (!bus.req_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) check("req_ready_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    // cycles counted from the accept edge; first negedge after it is cycle 1
    task automatic wait_rsp(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.rsp_valid && lat < 20);
    endtask

    task automatic consume();
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
    endtask

    task automatic check_rsp(input string tag, input vec_t v, input int lat);
        logic [W-1:0] exp_res;
        exp_res = exp_q.pop_front();
        check({tag, "_latency"}, 64'(lat), 64'(BYTES + 1));
        check({tag, "_result"},  64'(bus.result), 64'(exp_res));
        check({tag, "_cout"},    64'(bus.cout), 64'(v.cout));
        check({tag, "_flags"},   64'({bus.flag_z, bus.flag_n, bus.flag_v}),
              64'({v.z & FLAGS_ON, v.n & FLAGS_ON, v.v & FLAGS_ON}));
    endtask

    initial begin
        int lat;
        int seen;
        vec_t v;

        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        bus.op_a = '0;
        bus.op_b = '0;
        bus.sub  = 1'b0;
        bus.cin  = 1'b0;

        //          a             b             sub   cin   res           cout  z     n     v
        vecs[0] = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{32'h00000044, 32'h00000025, 1'b0, 1'b1, 32'h0000006A, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{32'h00000005, 32'h00000007, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{32'h00000007, 32'h00000005, 1'b1, 1'b0, 32'h00000002, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b1, 32'hACF13569, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{32'h00001234, 32'h00001234, 1'b1, 1'b1, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[9] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b1};

        // reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("in_reset_req_ready", 64'(bus.req_ready), 64'd0);
        rst_n = 1'b1;
        #1;
        check("rst_state",     64'(dbg_state), 64'(ST_IDLE));
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_req_ready", 64'(bus.req_ready), 64'd1);
        check("rst_result",    64'(bus.result), 64'd0);
        check("rst_cout_flags", 64'({bus.cout, bus.flag_z, bus.flag_n, bus.flag_v}), 64'd0);

        // table-driven vectors
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(vecs[i].res);
            issue(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin);
            wait_rsp(lat);
            check_rsp($sformatf("vec%0d", i), vecs[i], lat);
            consume();
        end

        // backpressure: response held for 10 cycles
        v = '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0, 1'b0};
        exp_q.push_back(v.res);
        issue(v.a, v.b, v.sub, v.cin);
        wait_rsp(lat);
        check_rsp("bp", v, lat);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("bp_hold%0d", i),
                  64'({bus.rsp_valid, bus.req_ready, bus.cout, bus.flag_z, bus.flag_n, bus.flag_v, bus.result}),
                  64'({1'b1, 1'b0, 1'b0, 3'b000, 32'h00010000}));
        end

        // release and accept a new request in the same cycle
        v = '{32'h00000100, 32'h00000001, 1'b1, 1'b0, 32'h000000FF, 1'b1, 1'b0, 1'b0, 1'b0};
        exp_q.push_back(v.res);
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1;
        bus.op_a = v.a;
        bus.op_b = v.b;
        bus.sub  = v.sub;
        bus.cin  = v.cin;
        #1;
        check("b2b_req_ready", 64'(bus.req_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b0;
        check("b2b_state_run", 64'(dbg_state), 64'(ST_RUN));
        wait_rsp(lat);
        check_rsp("b2b", v, lat);
        consume();

        // reset while idx=2 in RUN
        issue(32'h11111111, 32'h22222222, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("pre_rst_state_run", 64'(dbg_state), 64'(ST_RUN));
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("midrst_state",     64'(dbg_state), 64'(ST_IDLE));
        check("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("midrst_result",    64'(bus.result), 64'd0);
        check("midrst_req_ready", 64'(bus.req_ready), 64'd1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) seen++;
        end
        check("midrst_no_response", 64'(seen), 64'd0);

        // recovery after the abandoned operation
        v = '{32'h00000003, 32'h00000004, 1'b0, 1'b0, 32'h00000007, 1'b0, 1'b0, 1'b0, 1'b0};
        exp_q.push_back(v.res);
        issue(v.a, v.b, v.sub, v.cin);
        wait_rsp(lat);
        check_rsp("recover", v, lat);
        consume();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/multibyte_add_sequencer.md
# multibyte_add_sequencer

Sequences the team's existing 8-bit ripple-carry adder byte-serially to perform wide add/subtract operations. It chains the carry through a register, one byte per cycle, so wide operands reuse a single narrow adder. Requests arrive and responses leave through valid/ready handshakes. It sits beside the execute stage as a multi-cycle arithmetic unit.

## Interface
- BYTES, default 4: operand width in bytes; W = 8*BYTES; legal range 2..8.

Ports, clock and reset first:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when high together with req_valid.
- op_a  in  W  operand A.
- op_b  in  W  operand B.
- sub  in  1  1 = A − B, 0 = A + B + cin.
- cin  in  1  carry-in for add; ignored when sub=1.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer takes result.
- result  out  W  sum/difference.
- cout  out  1  final carry; for sub, 1 = no borrow (A ≥ B unsigned).
- flag_z, flag_n, flag_v  out  1 each  zero, negative (result MSB), signed overflow.

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - On accept, register A, and register B_eff = sub ? ~op_b : op_b.
  - Set carry = sub ? 1 : cin and idx = 0, then go to RUN.
- RUN, each cycle:
  - Drive adder with A[idx], B_eff[idx] and carry.
  - Write the adder sum into result byte idx.
  - Set carry <= adder co.
  - At idx = BYTES−1, go to DONE; otherwise idx++.
- DONE:
  - rsp_valid = 1.
  - On rsp_ready, go to IDLE, unless a new request is accepted in the same cycle, in which case go directly to RUN with the new operands.
- req_ready = (state==IDLE) | (state==DONE & rsp_ready). Deasserted during RUN and while rst_n=0.
- cout = final carry register.
- Flags, computed on entry to DONE:
  - flag_z = (result == 0).
  - flag_n = result[W−1].
  - flag_v = (A[W−1] == B_eff[W−1]) & (result[W−1] != A[W−1]).
- Reset (rst_n low at an edge):
  - state = IDLE, idx = 0, carry = 0.
  - result = 0, cout = 0, all flags = 0, rsp_valid = 0.
- Reset mid-RUN or mid-DONE abandons the operation; no response is ever produced for it.

## Timing
- Request accepted at edge T. RUN occupies cycles T+1..T+BYTES. rsp_valid is high from cycle T+BYTES+1.
- Latency is BYTES+1 cycles. Back-to-back throughput is one operation per BYTES+1 cycles when rsp_ready is held high.
- While rsp_valid=1 and rsp_ready=0, result, cout and flags hold stable, and req_ready=0.
- result bytes update during RUN; they are meaningful only when rsp_valid=1.
- req_ready depends combinationally on rsp_ready. No other input-to-output combinational paths exist.

## Configuration
- MBADD_FLAGS_EN defined: flag_z, flag_n and flag_v are computed as above, and the MSB capture registers exist.
- MBADD_FLAGS_EN undefined: the flag ports remain and are tied to 0, and the flag logic and MSB registers are removed.
- cout and result behave the same in both builds.

## Structure
- Shared package holds:
  - the state enum (IDLE/RUN/DONE);
  - the byte-index width constant $clog2(BYTES_MAX=8);
  - the byte width constant 8.
- Sub-module: one instance of ripple_carry_adder_8 (a, b, ci, o, co), the team's existing 8-bit adder. It is the only arithmetic in the block.

## Test plan
- BYTES=4, add, a=0x000000FF, b=0x00000001, cin=0 -> result=0x00000100, cout=0, Z/N/V=0, rsp_valid exactly 5 cycles after accept.
- add a=0xFFFFFFFF, b=0x00000001, cin=0 -> result=0x00000000, cout=1, flag_z=1. Separately, add a=0x44, b=0x25, cin=1 -> result=0x0000006A, cout=0.
- add a=0x7FFFFFFF, b=0x00000001 -> result=0x80000000, flag_n=1, flag_v=1, cout=0.
- sub a=0x00000005, b=0x00000007 -> result=0xFFFFFFFE, cout=0 (borrow), flag_n=1, flag_v=0. Separately, sub a=7, b=5 -> result=0x00000002, cout=1.
- Backpressure:
  - Hold rsp_ready=0 for 10 cycles in DONE -> outputs stable, req_ready=0.
  - Then raise rsp_ready=1 with req_valid=1 in the same cycle -> new request accepted that cycle; its rsp_valid follows 5 cycles later.
- Reset: drive rst_n=0 for one edge while idx=2 in RUN -> next cycle state IDLE, rsp_valid=0, result=0, req_ready=1. No response is produced for the abandoned operation.
